// File: rtl/srv1_pkg.sv
// Shared types and constants for the core-side memory bridge.
package srv1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    I_REQ,
    I_WAIT,
    STEP
  } bridge_state_t;

  // addi x0,x0,0 in the core's little-endian port order
  localparam logic [31:0] NOP_WORD_LE = 32'h1300_0000;

endpackage

// File: rtl/core_mem_bridge.sv
// Sequences one core step over a shared valid/ready memory port: optional data
// access, then instruction fetch, then a single-cycle core clock enable.
//
// state  | meaning
// IDLE   | waiting for run; core clock held
// D_REQ  | presenting the core's load/store request
// D_WAIT | waiting for the data response (store response is only an ack)
// I_REQ  | presenting the instruction fetch request
// I_WAIT | waiting for the instruction word
// STEP   | core_clk_en high for exactly one cycle
module core_mem_bridge
  import srv1_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_LE
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        run,
  output logic        core_clk_en,
  input  logic [29:0] core_inst_address,
  input  logic        core_bus_lock,
  input  logic        core_memory_mode,
  input  logic [29:0] core_data_address,
  input  logic [3:0]  core_data_mask,
  input  logic [31:0] core_data_out,
  output logic [31:0] core_inst_in,
  output logic [31:0] core_data_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  bridge_state_t state_q, state_d;
  logic [31:0]   inst_hold_q;
  logic [31:0]   data_pending_q;
  logic [31:0]   data_hold_q;
  logic          step_load_q;

  // Core inputs are frozen while clk_en is low, so request fields can be
  // driven straight from them and stay constant under backpressure.
  always_comb begin
    state_d       = state_q;
    core_clk_en   = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wmask     = '0;
    mem_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (run) state_d = core_bus_lock ? D_REQ : I_REQ;
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = core_data_address;
        mem_we        = core_memory_mode;
        mem_wmask     = core_memory_mode ? core_data_mask : 4'hF;
        mem_wdata     = core_data_out;
        if (mem_req_ready) state_d = D_WAIT;
      end
      D_WAIT: begin
        if (mem_rsp_valid) state_d = I_REQ;
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = core_inst_address;
        mem_wmask     = 4'hF;
        if (mem_req_ready) state_d = I_WAIT;
      end
      I_WAIT: begin
        if (mem_rsp_valid) state_d = STEP;
      end
      STEP: begin
        core_clk_en = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // data_hold lags data_pending by one step: writeback consumes load data
  // one core step after the memory stage issued the address.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q        <= IDLE;
      inst_hold_q    <= NOP_WORD;
      data_pending_q <= '0;
      data_hold_q    <= '0;
      step_load_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && run)
        step_load_q <= core_bus_lock & ~core_memory_mode;
      if (state_q == D_WAIT && mem_rsp_valid && step_load_q)
        data_pending_q <= mem_rsp_data;
      if (state_q == I_WAIT && mem_rsp_valid)
        inst_hold_q <= mem_rsp_data;
      if (state_q == STEP && step_load_q)
        data_hold_q <= data_pending_q;
    end
  end

  assign core_inst_in = inst_hold_q;
  assign core_data_in = data_hold_q;

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: table of core steps against a
// zero-wait memory responder, plus backpressure, run-drop and reset sequences.
module tb_core_mem_bridge;
  import srv1_pkg::*;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        run = 1'b0;
  logic        core_clk_en;
  logic [29:0] core_inst_address = '0;
  logic        core_bus_lock = 1'b0;
  logic        core_memory_mode = 1'b0;
  logic [29:0] core_data_address = '0;
  logic [3:0]  core_data_mask = '0;
  logic [31:0] core_data_out = '0;
  logic [31:0] core_inst_in;
  logic [31:0] core_data_in;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  core_mem_bridge dut (
    .clk(clk), .async_rst_n(async_rst_n), .run(run), .core_clk_en(core_clk_en),
    .core_inst_address(core_inst_address), .core_bus_lock(core_bus_lock),
    .core_memory_mode(core_memory_mode), .core_data_address(core_data_address),
    .core_data_mask(core_data_mask), .core_data_out(core_data_out),
    .core_inst_in(core_inst_in), .core_data_in(core_data_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: accepts at negedge+2 (inputs settled), answers one cycle later.
  logic [31:0] drsp = '0, irsp = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  always begin
    @(negedge clk);
    #2;
    mem_rsp_valid = 1'b0;
    if (pend) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend_data;
      pend          = 1'b0;
    end
    if (mem_req_valid && mem_req_ready) begin
      pend = 1'b1;
      if (mem_we) pend_data = 32'h5A5A_5A5A;
      else if (mem_addr == core_inst_address) pend_data = irsp;
      else pend_data = drsp;
    end
  end

  typedef struct {
    logic        lock;
    logic        mode;
    logic [29:0] daddr;
    logic [3:0]  mask;
    logic [31:0] dout;
    logic [29:0] iaddr;
    logic [31:0] d_rsp;
    logic [31:0] i_rsp;
    int          exp_cyc;
    logic        exp_we;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_step(input vec_t v, input int idx);
    int n;
    logic [31:0] old;
    logic stable;
    @(negedge clk);
    core_bus_lock     = v.lock;
    core_memory_mode  = v.mode;
    core_data_address = v.daddr;
    core_data_mask    = v.mask;
    core_data_out     = v.dout;
    core_inst_address = v.iaddr;
    drsp = v.d_rsp;
    irsp = v.i_rsp;
    run  = 1'b1;
    old  = core_data_in;
    stable = 1'b1;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (core_data_in !== old) stable = 1'b0;
      if (n == 2) begin
        chk($sformatf("v%0d req_valid", idx), {31'b0, mem_req_valid}, 32'd1);
        chk($sformatf("v%0d req_addr", idx), {2'b0, mem_addr}, {2'b0, v.lock ? v.daddr : v.iaddr});
        chk($sformatf("v%0d req_we", idx), {31'b0, mem_we}, {31'b0, v.exp_we});
        chk($sformatf("v%0d req_wmask", idx), {28'b0, mem_wmask}, {28'b0, v.exp_wmask});
        chk($sformatf("v%0d req_wdata", idx), mem_wdata, v.lock ? v.dout : 32'h0);
      end
      if (core_clk_en) break;
    end
    run = 1'b0;
    chk($sformatf("v%0d step_cycles", idx), n, v.exp_cyc);
    chk($sformatf("v%0d data_stable_until_step", idx), {31'b0, stable}, 32'd1);
    chk($sformatf("v%0d inst_in", idx), core_inst_in, v.exp_inst);
    @(negedge clk);
    chk($sformatf("v%0d clk_en_single", idx), {31'b0, core_clk_en}, 32'd0);
    chk($sformatf("v%0d data_in_after", idx), core_data_in, v.exp_data);
  endtask

  task automatic wait_clk_en(output int n);
    n = 1;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (core_clk_en) break;
    end
  endtask

  initial begin
    int n;
    logic ok;
    //          lock mode daddr  mask  dout          iaddr  d_rsp         i_rsp         cyc we wm    inst          data
    vecs[0] = '{1'b0, 1'b0, 30'h0,  4'h0, 32'h0,        30'h10, 32'h0,        32'hDEAD_BEEF, 4, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 30'h40, 4'h0, 32'h1111_1111, 30'h11, 32'h1234_5678, 32'h0000_0013, 6, 1'b0, 4'hF, 32'h0000_0013, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 30'h44, 4'h1, 32'h0,        30'h12, 32'hCAFE_F00D, 32'h0010_0093, 6, 1'b0, 4'hF, 32'h0010_0093, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 30'h48, 4'h3, 32'hAABB_CCDD, 30'h13, 32'h7777_7777, 32'h0020_0113, 6, 1'b1, 4'h3, 32'h0020_0113, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 30'h0,  4'h0, 32'h0,        30'h14, 32'h0,        32'h0030_0193, 4, 1'b0, 4'hF, 32'h0030_0193, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, 30'h4C, 4'hF, 32'h0102_0304, 30'h15, 32'h0,        32'h0040_0213, 6, 1'b1, 4'hF, 32'h0040_0213, 32'hCAFE_F00D};

    repeat (3) @(negedge clk);
    chk("rst clk_en", {31'b0, core_clk_en}, 32'd0);
    chk("rst req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst fields", {mem_addr, mem_we, mem_wmask, mem_wdata} == '0 ? 32'd0 : 32'd1, 32'd0);
    chk("rst inst_in", core_inst_in, 32'h1300_0000);
    chk("rst data_in", core_data_in, 32'h0);
    async_rst_n = 1'b1;

    foreach (vecs[i]) run_step(vecs[i], i);

    // Backpressure: ready low for 5 cycles in I_REQ
    @(negedge clk);
    core_bus_lock = 1'b0;
    core_inst_address = 30'h20;
    irsp = 32'h0050_0293;
    mem_req_ready = 1'b0;
    run = 1'b1;
    ok = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (!mem_req_valid || mem_addr !== 30'h20 || mem_we !== 1'b0 ||
          mem_wmask !== 4'hF || mem_wdata !== 32'h0 || core_clk_en) ok = 1'b0;
    end
    chk("bp held_fields", {31'b0, ok}, 32'd1);
    @(negedge clk);
    mem_req_ready = 1'b1;
    n = 7;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (core_clk_en) break;
    end
    run = 1'b0;
    chk("bp step_cycles", n, 9);
    chk("bp inst_in", core_inst_in, 32'h0050_0293);

    // run dropped in I_WAIT
    repeat (2) @(negedge clk);
    core_inst_address = 30'h21;
    irsp = 32'h0060_0313;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("rundrop clk_en", {31'b0, core_clk_en}, 32'd1);
    chk("rundrop inst_in", core_inst_in, 32'h0060_0313);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_req_valid || core_clk_en) ok = 1'b0;
    end
    chk("rundrop parked", {31'b0, ok}, 32'd1);
    run = 1'b1;
    wait_clk_en(n);
    run = 1'b0;
    chk("rundrop resume_cycles", n, 4);

    // Reset during D_WAIT of a load
    repeat (2) @(negedge clk);
    core_bus_lock = 1'b1;
    core_memory_mode = 1'b0;
    core_data_address = 30'h50;
    core_inst_address = 30'h22;
    drsp = 32'h8888_9999;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    #1 async_rst_n = 1'b0;
    #1;
    chk("arst clk_en", {31'b0, core_clk_en}, 32'd0);
    chk("arst req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("arst inst_in", core_inst_in, 32'h1300_0000);
    chk("arst data_in", core_data_in, 32'h0);
    #1 async_rst_n = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_req_valid || core_clk_en || core_data_in !== 32'h0 ||
          core_inst_in !== 32'h1300_0000) ok = 1'b0;
    end
    chk("arst late_rsp_ignored", {31'b0, ok}, 32'd1);

    run_step('{1'b1, 1'b0, 30'h54, 4'h0, 32'h0, 30'h23, 32'h4242_4242, 32'h0070_0393,
               6, 1'b0, 4'hF, 32'h0070_0393, 32'h4242_4242}, 90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
